// File: rtl/model_trainer_integration_pkg.sv
// Shared constants and types for the trainer integration stage.
// Holds the element width, the accumulator depth and the saturation limits.
package model_trainer_integration_pkg;

    localparam int DATA_SIZE    = 64;
    localparam int CONTROL_SIZE = 64;
    localparam int SIZE_I_MAX   = 64;

    // Index width addresses the array; count width can also hold SIZE_I_MAX itself.
    localparam int IDX_W = $clog2(SIZE_I_MAX);
    localparam int CNT_W = $clog2(SIZE_I_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_ACCUMULATE = 2'd1,
        ST_OUTPUT     = 2'd2
    } state_t;

    localparam logic signed [DATA_SIZE-1:0] MAX_POS = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [DATA_SIZE-1:0] MAX_NEG = {1'b1, {(DATA_SIZE-1){1'b0}}};

endpackage

// File: rtl/model_trainer_saturating_adder.sv
// Combinational signed adder that clamps to the representable range.
// Raises o_overflow whenever the result had to be clamped.
module model_trainer_saturating_adder
    import model_trainer_integration_pkg::*;
(
    input  logic signed [DATA_SIZE-1:0] i_a,
    input  logic signed [DATA_SIZE-1:0] i_b,
    output logic signed [DATA_SIZE-1:0] o_sum,
    output logic                        o_overflow
);

    logic signed [DATA_SIZE-1:0] w_raw;

    assign w_raw = i_a + i_b;

    // Overflow only happens when both operands share a sign and the result flips it.
    assign o_overflow = (i_a[DATA_SIZE-1] == i_b[DATA_SIZE-1]) &&
                        (w_raw[DATA_SIZE-1] != i_a[DATA_SIZE-1]);

    assign o_sum = o_overflow ? (i_a[DATA_SIZE-1] ? MAX_NEG : MAX_POS) : w_raw;

endmodule

// File: rtl/model_trainer_integration.sv
// Integrates a t-major stream of derivative vectors over SIZE_T steps and
// streams the integral back out one element per cycle, index 0 first.
module model_trainer_integration
    import model_trainer_integration_pkg::*;
(
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           START,
    output logic                           READY,
    input  logic [CONTROL_SIZE-1:0]        SIZE_I_IN,
    input  logic [CONTROL_SIZE-1:0]        SIZE_T_IN,
    input  logic                           DATA_IN_ENABLE,
    input  logic signed [DATA_SIZE-1:0]    DATA_IN,
    output logic                           DATA_IN_READY,
    output logic                           DATA_OUT_ENABLE,
    output logic signed [DATA_SIZE-1:0]    DATA_OUT,
    output logic                           OVERFLOW
);

    state_t                      r_state;
    logic [CNT_W-1:0]            r_size_i;
    logic [CNT_W-1:0]            r_index_i;
    logic [CONTROL_SIZE-1:0]     r_size_t;
    logic [CONTROL_SIZE-1:0]     r_index_t;
    logic                        r_dout_en;
    logic signed [DATA_SIZE-1:0] r_dout;
    logic                        r_overflow;
    logic signed [DATA_SIZE-1:0] r_acc [SIZE_I_MAX];

    logic                        w_start_ok;
    logic                        w_accept;
    logic                        w_last_i;
    logic                        w_last_t;
    logic                        w_first_t;
    logic [CNT_W-1:0]            w_size_i_clamped;
    logic signed [DATA_SIZE-1:0] w_acc_rd;
    logic signed [DATA_SIZE-1:0] w_sum;
    logic signed [DATA_SIZE-1:0] w_wr_data;
    logic                        w_add_ovf;

    // READY stays low through the last output cycle so a run never overlaps its own tail.
    assign READY           = (r_state == ST_IDLE) && !r_dout_en;
    assign DATA_IN_READY   = (r_state == ST_ACCUMULATE);
    assign DATA_OUT_ENABLE = r_dout_en;
    assign DATA_OUT        = r_dout;
    assign OVERFLOW        = r_overflow;

    assign w_start_ok = START && READY;
    assign w_accept   = DATA_IN_ENABLE && DATA_IN_READY;
    assign w_last_i   = (r_index_i == r_size_i - CNT_W'(1));
    assign w_last_t   = (r_index_t == r_size_t - CONTROL_SIZE'(1));
    assign w_first_t  = (r_index_t == '0);

    assign w_size_i_clamped = (SIZE_I_IN > CONTROL_SIZE'(SIZE_I_MAX)) ?
                              CNT_W'(SIZE_I_MAX) : SIZE_I_IN[CNT_W-1:0];

    assign w_acc_rd  = r_acc[r_index_i[IDX_W-1:0]];
    // The first time step overwrites, so stale contents never need clearing.
    assign w_wr_data = w_first_t ? DATA_IN : w_sum;

    model_trainer_saturating_adder u_sat_add (
        .i_a        (w_acc_rd),
        .i_b        (DATA_IN),
        .o_sum      (w_sum),
        .o_overflow (w_add_ovf)
    );

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_acc[r_index_i[IDX_W-1:0]] <= w_wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_size_i   <= '0;
            r_index_i  <= '0;
            r_size_t   <= '0;
            r_index_t  <= '0;
            r_dout_en  <= 1'b0;
            r_dout     <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_dout_en <= 1'b0;
                    if (w_start_ok) begin
                        r_size_i   <= w_size_i_clamped;
                        r_size_t   <= SIZE_T_IN;
                        r_index_i  <= '0;
                        r_index_t  <= '0;
                        r_overflow <= 1'b0;
                        if ((SIZE_I_IN != '0) && (SIZE_T_IN != '0)) begin
                            r_state <= ST_ACCUMULATE;
                        end
                    end
                end
                ST_ACCUMULATE: begin
                    if (w_accept) begin
                        if (!w_first_t && w_add_ovf) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_last_i) begin
                            r_index_i <= '0;
                            if (w_last_t) begin
                                r_state <= ST_OUTPUT;
                            end else begin
                                r_index_t <= r_index_t + CONTROL_SIZE'(1);
                            end
                        end else begin
                            r_index_i <= r_index_i + CNT_W'(1);
                        end
                    end
                end
                ST_OUTPUT: begin
                    r_dout    <= w_acc_rd;
                    r_dout_en <= 1'b1;
                    if (w_last_i) begin
                        r_index_i <= '0;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_index_i <= r_index_i + CNT_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_model_trainer_integration.sv
// Self-checking bench for model_trainer_integration: directed scenarios plus
// randomized runs compared against a saturating-sum reference model.
module tb_model_trainer_integration;

    localparam int MAXI = 64;
    localparam logic signed [64:0] LIM_P = (65'sd1 <<< 63) - 65'sd1;
    localparam logic signed [64:0] LIM_N = -(65'sd1 <<< 63);

    logic               clk = 1'b0;
    logic               RST = 1'b0;
    logic               START = 1'b0;
    logic               READY;
    logic [63:0]        SIZE_I_IN = '0;
    logic [63:0]        SIZE_T_IN = '0;
    logic               DATA_IN_ENABLE = 1'b0;
    logic signed [63:0] DATA_IN = '0;
    logic               DATA_IN_READY;
    logic               DATA_OUT_ENABLE;
    logic signed [63:0] DATA_OUT;
    logic               OVERFLOW;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic signed [63:0] stim_q[$];
    logic signed [63:0] exp_q[$];
    logic signed [63:0] out_q[$];
    int                 out_cyc_q[$];
    logic               exp_ovf;

    model_trainer_integration dut (
        .CLK             (clk),
        .RST             (RST),
        .START           (START),
        .READY           (READY),
        .SIZE_I_IN       (SIZE_I_IN),
        .SIZE_T_IN       (SIZE_T_IN),
        .DATA_IN_ENABLE  (DATA_IN_ENABLE),
        .DATA_IN         (DATA_IN),
        .DATA_IN_READY   (DATA_IN_READY),
        .DATA_OUT_ENABLE (DATA_OUT_ENABLE),
        .DATA_OUT        (DATA_OUT),
        .OVERFLOW        (OVERFLOW)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (DATA_OUT_ENABLE === 1'b1) begin
            out_q.push_back(DATA_OUT);
            out_cyc_q.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    // Reference: plain per-element sum over time steps, clamped after every step.
    task automatic model(input int n, input int t);
        logic signed [63:0] acc [MAXI];
        logic signed [64:0] s;
        logic signed [63:0] v;
        exp_ovf = 1'b0;
        exp_q.delete();
        for (int tt = 0; tt < t; tt++) begin
            for (int ii = 0; ii < n; ii++) begin
                v = stim_q[tt * n + ii];
                if (tt == 0) begin
                    acc[ii] = v;
                end else begin
                    s = {acc[ii][63], acc[ii]} + {v[63], v};
                    if (s > LIM_P) begin
                        acc[ii] = LIM_P[63:0];
                        exp_ovf = 1'b1;
                    end else if (s < LIM_N) begin
                        acc[ii] = LIM_N[63:0];
                        exp_ovf = 1'b1;
                    end else begin
                        acc[ii] = s[63:0];
                    end
                end
            end
        end
        for (int ii = 0; ii < n; ii++) exp_q.push_back(acc[ii]);
    endtask

    task automatic run_case(input string name, input longint unsigned si_in,
                            input longint unsigned st_in, input int min_gap,
                            input int max_gap, input bit noise);
        int n;
        int t;
        int last_cyc;
        int bound;
        n = (si_in > MAXI) ? MAXI : int'(si_in);
        t = int'(st_in);
        model(n, t);
        out_q.delete();
        out_cyc_q.delete();
        @(posedge clk); #1;
        START = 1'b1; SIZE_I_IN = si_in; SIZE_T_IN = st_in;
        @(posedge clk); #1;
        START = 1'b0;
        SIZE_I_IN = {$urandom, $urandom};
        SIZE_T_IN = {$urandom, $urandom};
        last_cyc = 0;
        for (int k = 0; k < n * t; k++) begin
            DATA_IN_ENABLE = 1'b0;
            START = 1'b0;
            repeat ($urandom_range(max_gap, min_gap)) begin
                @(posedge clk); #1;
            end
            DATA_IN_ENABLE = 1'b1;
            DATA_IN = stim_q[k];
            START = noise;
            last_cyc = cyc;
            @(posedge clk); #1;
        end
        DATA_IN_ENABLE = 1'b0;
        START = 1'b0;
        bound = 0;
        while (!(out_q.size() >= n && READY === 1'b1) && bound < n + 20) begin
            if (noise && out_q.size() < n - 1) begin
                START = 1'b1; DATA_IN_ENABLE = 1'b1; DATA_IN = {$urandom, $urandom};
            end else begin
                START = 1'b0; DATA_IN_ENABLE = 1'b0;
            end
            @(posedge clk); #1;
            bound++;
        end
        START = 1'b0; DATA_IN_ENABLE = 1'b0;
        checks++;
        if (out_q.size() !== n || READY !== 1'b1) begin
            errors++;
            $display("FAIL %s count: got %0d outputs ready=%b, expected %0d outputs ready=1",
                     name, out_q.size(), READY, n);
        end
        for (int j = 0; j < n && j < out_q.size(); j++) begin
            checks++;
            if (out_q[j] !== exp_q[j]) begin
                errors++;
                $display("FAIL %s data[%0d]: got %0d, expected %0d", name, j, out_q[j], exp_q[j]);
            end
            checks++;
            if (out_cyc_q[j] !== out_cyc_q[0] + j) begin
                errors++;
                $display("FAIL %s spacing[%0d]: got cycle %0d, expected %0d",
                         name, j, out_cyc_q[j], out_cyc_q[0] + j);
            end
        end
        if (out_q.size() > 0) begin
            checks++;
            if (out_cyc_q[0] !== last_cyc + 2) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles, expected 2", name, out_cyc_q[0] - last_cyc);
            end
        end
        checks++;
        if (OVERFLOW !== exp_ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b, expected %b", name, OVERFLOW, exp_ovf);
        end
        @(negedge clk);
        checks++;
        if (DATA_OUT_ENABLE !== 1'b0 || DATA_IN_READY !== 1'b0 || DATA_OUT !== exp_q[n-1]) begin
            errors++;
            $display("FAIL %s idle_after: got en=%b in_rdy=%b out=%0d, expected en=0 in_rdy=0 out=%0d",
                     name, DATA_OUT_ENABLE, DATA_IN_READY, DATA_OUT, exp_q[n-1]);
        end
        $display("run %s: size_i=%0d size_t=%0d outputs=%0d overflow=%b", name, n, t, out_q.size(), OVERFLOW);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        checks++;
        if (READY !== 1'b1) begin errors++; $display("FAIL reset READY: got %b, expected 1", READY); end
        checks++;
        if (DATA_IN_READY !== 1'b0) begin errors++; $display("FAIL reset DATA_IN_READY: got %b, expected 0", DATA_IN_READY); end
        checks++;
        if (DATA_OUT_ENABLE !== 1'b0) begin errors++; $display("FAIL reset DATA_OUT_ENABLE: got %b, expected 0", DATA_OUT_ENABLE); end
        checks++;
        if (DATA_OUT !== 64'sd0) begin errors++; $display("FAIL reset DATA_OUT: got %0d, expected 0", DATA_OUT); end
        checks++;
        if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset OVERFLOW: got %b, expected 0", OVERFLOW); end
        $display("reset: ready=%b in_ready=%b out_en=%b", READY, DATA_IN_READY, DATA_OUT_ENABLE);
    endtask

    task automatic test_basic;
        stim_q = '{64'sd1, 64'sd2, 64'sd3, 64'sd10, 64'sd20, 64'sd30};
        run_case("basic", 3, 2, 0, 0, 1'b0);
    endtask

    task automatic test_negative_gapped;
        stim_q = '{-64'sd5, 64'sd4, -64'sd5, 64'sd4, 64'sd2, -64'sd20};
        run_case("neg_gapped", 2, 3, 1, 3, 1'b0);
    endtask

    task automatic test_saturation;
        stim_q = '{64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000};
        run_case("sat_pos", 1, 2, 0, 0, 1'b0);
        stim_q = '{64'sd1, 64'sd1};
        run_case("after_sat", 1, 2, 0, 0, 1'b0);
        stim_q = '{64'sh8000_0000_0000_0000, -64'sd1, 64'sd5};
        run_case("sat_neg", 1, 3, 0, 1, 1'b0);
    endtask

    task automatic zero_check(input string name, input longint unsigned si, input longint unsigned st);
        @(posedge clk); #1;
        START = 1'b1; SIZE_I_IN = si; SIZE_T_IN = st;
        @(posedge clk); #1;
        START = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (READY !== 1'b1 || DATA_OUT_ENABLE !== 1'b0 || DATA_IN_READY !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: got ready=%b out_en=%b in_rdy=%b, expected 1 0 0",
                         name, k, READY, DATA_OUT_ENABLE, DATA_IN_READY);
            end
        end
        $display("zero %s: ready=%b out_en=%b", name, READY, DATA_OUT_ENABLE);
    endtask

    task automatic test_zero_size;
        zero_check("size_i_zero", 0, 5);
        zero_check("size_t_zero", 3, 0);
    endtask

    task automatic test_reset_mid_run;
        @(posedge clk); #1;
        START = 1'b1; SIZE_I_IN = 3; SIZE_T_IN = 2;
        @(posedge clk); #1;
        START = 1'b0;
        for (int k = 0; k < 2; k++) begin
            DATA_IN_ENABLE = 1'b1; DATA_IN = 64'sd1000 + k;
            @(posedge clk); #1;
        end
        DATA_IN_ENABLE = 1'b0;
        RST = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        checks++;
        if (READY !== 1'b1 || DATA_IN_READY !== 1'b0 || DATA_OUT_ENABLE !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset state: got ready=%b in_rdy=%b out_en=%b, expected 1 0 0",
                     READY, DATA_IN_READY, DATA_OUT_ENABLE);
        end
        $display("mid_reset: ready=%b in_ready=%b", READY, DATA_IN_READY);
        stim_q = '{64'sd7, 64'sd9};
        run_case("after_reset", 2, 1, 0, 0, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        stim_q = '{64'sd1, 64'sd2, 64'sd3, 64'sd10, 64'sd20, 64'sd30};
        run_case("noise", 3, 2, 0, 2, 1'b1);
    endtask

    task automatic test_clamp;
        stim_q.delete();
        for (int k = 0; k < 2 * MAXI; k++) stim_q.push_back(64'(signed'($urandom_range(2000, 0))) - 64'sd1000);
        run_case("clamp", 100, 2, 0, 0, 1'b0);
    endtask

    task automatic test_random;
        int n;
        int t;
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(8, 1);
            t = $urandom_range(4, 1);
            stim_q.delete();
            for (int k = 0; k < n * t; k++) begin
                if ($urandom_range(3, 0) == 0) stim_q.push_back({$urandom, $urandom});
                else stim_q.push_back(64'(signed'($urandom_range(200, 0))) - 64'sd100);
            end
            run_case($sformatf("random%0d", r), n, t, 0, 2, r[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_gapped();
        test_saturation();
        test_zero_size();
        test_reset_mid_run();
        test_ignored_inputs();
        test_clamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
